// File: rtl/booth_datapath.sv
// ---------------------------------------------------------------------------
// booth_datapath
//
// Register datapath for a radix-2 Booth multiplier. It holds the M, A, Q and
// Qprev registers and obeys the control strobes from the multiplier FSM. It
// returns the current Booth bit pair to the FSM. On a mult_DONE rising edge it
// captures the signed 2N-bit product.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset; clears every register
//   multiplicand  N-bit operand, loaded into M on load_M
//   multiplier    N-bit operand, loaded into Q on load_Q
//   load_M        M <= multiplicand
//   load_Q        Q <= multiplier
//   reset_A       A <= 0
//   reset_Qprev   Qprev <= 0
//   add_M         A <= A + M
//   subs_M        A <= A - M
//   shift_all     arithmetic right shift of {A,Q,Qprev}, fused after add/sub
//   mult_DONE     completion level from the FSM; its rising edge captures
//   Qo_Qprev      {Q[0], Qprev}, combinational from the registers
//   product       signed 2N-bit product, held until the next capture
//   product_valid one-cycle pulse in the cycle where product has just updated
//   ctrl_err      one-cycle pulse after an illegal control combination
//
// Handshake: product_valid is a push-only strobe with no ready. The consumer
// must take product in the single cycle that product_valid is high. After
// that, product stays stable until the next capture, so a late reader still
// sees the same value.
// ---------------------------------------------------------------------------
module booth_datapath #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    input  logic             load_M,
    input  logic             load_Q,
    input  logic             reset_A,
    input  logic             reset_Qprev,
    input  logic             add_M,
    input  logic             subs_M,
    input  logic             shift_all,
    input  logic             mult_DONE,
    output logic [1:0]       Qo_Qprev,
    output logic [2*N-1:0]   product,
    output logic             product_valid,
    output logic             ctrl_err
);

    logic [N-1:0] m_reg;
    logic [N-1:0] q_reg;
    logic [N:0]   a_reg;      // one extra bit so that A - (-2^(N-1)) fits
    logic         qprev_reg;
    logic         mult_done_q;

    logic [N:0]   m_ext;
    logic [N:0]   a_arith;    // A after the add/sub priority rules (A')
    logic         init_any;
    logic         addsub_err;
    logic         do_shift;
    logic         done_rise;

    assign m_ext     = {m_reg[N-1], m_reg};
    assign init_any  = load_M | load_Q | reset_A | reset_Qprev;
    // reset_A outranks the add/sub conflict, so that case is not an error
    assign addsub_err = add_M & subs_M & ~reset_A;
    // init strobes suppress a concurrent shift
    assign do_shift  = shift_all & ~init_any;
    assign done_rise = mult_DONE & ~mult_done_q;

    assign Qo_Qprev  = {q_reg[0], qprev_reg};

    always_comb begin
        a_arith = a_reg;
        if (reset_A) begin
            a_arith = '0;
        end else if (add_M && subs_M) begin
            a_arith = a_reg;
        end else if (add_M) begin
            a_arith = a_reg + m_ext;
        end else if (subs_M) begin
            a_arith = a_reg - m_ext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_reg     <= '0;
            q_reg     <= '0;
            a_reg     <= '0;
            qprev_reg <= 1'b0;
        end else begin
            if (load_M) begin
                m_reg <= multiplicand;
            end
            if (do_shift) begin
                a_reg     <= {a_arith[N], a_arith[N:1]};
                q_reg     <= {a_arith[0], q_reg[N-1:1]};
                qprev_reg <= q_reg[0];
            end else begin
                a_reg <= a_arith;
                if (load_Q) begin
                    q_reg <= multiplier;
                end
                if (reset_Qprev) begin
                    qprev_reg <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_err <= 1'b0;
        end else begin
            ctrl_err <= addsub_err | (shift_all & init_any);
        end
    end

    // Edge detect on mult_DONE. The history register clears on reset, so a
    // level that is already high at reset release counts as a rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mult_done_q   <= 1'b0;
            product       <= '0;
            product_valid <= 1'b0;
        end else begin
            mult_done_q   <= mult_DONE;
            product_valid <= done_rise;
            if (done_rise) begin
                product <= {a_reg[N-1:0], q_reg};
            end
        end
    end

endmodule

// File: doc/booth_datapath.md
Name: booth_datapath

Overview:
- Register datapath for the radix-2 Booth multiplier; sits directly downstream of multiplier_FSM.
- Consumes the FSM's control strobes and holds the M, A, Q and Qprev registers.
- Returns Qo_Qprev to the FSM.
- When the FSM asserts mult_DONE, captures the signed 2N-bit product and flags it valid for one cycle.

Parameters:
- N, 8, operand width in bits; operands and product are two's complement; N >= 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; low clears all registers
- multiplicand  in  N  operand captured into M on load_M
- multiplier  in  N  operand captured into Q on load_Q
- load_M  in  1  M <= multiplicand
- load_Q  in  1  Q <= multiplier
- reset_A  in  1  A <= 0
- reset_Qprev  in  1  Qprev <= 0
- add_M  in  1  A <= A + M
- subs_M  in  1  A <= A - M
- shift_all  in  1  arithmetic right shift of {A,Q,Qprev}
- mult_DONE  in  1  FSM completion level; product captured on its rising edge
- Qo_Qprev  out  2  {Q[0], Qprev}, combinational from registers
- product  out  2N  signed product, held until the next capture
- product_valid  out  1  one-cycle pulse when product updates
- ctrl_err  out  1  one-cycle pulse on an illegal control combination

Behaviour:
- Reset (reset low, async): M, Q, A, Qprev, product = 0; product_valid = 0; ctrl_err = 0; internal mult_DONE history = 0.
- Register widths:
  - M and Q are N bits.
  - A is N+1 bits so that M = -2^(N-1) is handled without overflow.
  - M is sign-extended to N+1 bits for add/sub.
  - A arithmetic wraps modulo 2^(N+1).
- Init group: load_M, load_Q, reset_A, reset_Qprev act independently, all in the same cycle if asserted together.
- A update priority, highest first:
  1. reset_A
  2. add_M and subs_M both high: A holds, ctrl_err pulses
  3. add_M
  4. subs_M
  5. hold
- Arithmetic result (A') is the value of A after the priority rules above are applied.
- shift_all (only when no init-group signal is high), all in one cycle:
  - A <= {A'[N], A'[N:1]}
  - Q <= {A'[0], Q[N-1:1]}
  - Qprev <= Q[0]
  - add/sub and shift in the same cycle therefore form a fused add-then-shift.
- shift_all while any init-group signal is high: the shift is suppressed, the init actions apply, ctrl_err pulses.
- Qo_Qprev reflects the registered state with zero latency; the FSM samples it on the next edge.
- Product capture:
  - mult_DONE is registered into mult_DONE_q.
  - On a cycle where mult_DONE=1 and mult_DONE_q=0: product <= {A[N-1:0], Q}, and product_valid is 1 for exactly the following cycle.
  - If mult_DONE stays high for several cycles, only one capture and one pulse occur.
  - If mult_DONE is high during reset release, the first sampled high cycle after release counts as the rising edge.
- Product values:
  - product keeps its value across new loads until the next capture.
  - M, Q and A are not cleared by capture.
- Reset mid-operation: everything returns to its reset values immediately; no partial product is presented.
- Latency: load to Qo_Qprev valid is 1 cycle. mult_DONE rise to product/product_valid is 1 cycle.
- No internal iteration counter: the iteration count is owned by the FSM (N shift cycles).

Test Plan:
- Reset, then load_M=1 with multiplicand=0x05 and load_Q=1 with multiplier=0x03, reset_A, reset_Qprev -> Qo_Qprev=2'b10, A=0.
- From that state, subs_M -> A=0x1FB (N+1 bits); then shift_all -> A=0x1FD, Q=0x81, Qprev=1, Qo_Qprev=2'b11.
- Bench-modelled FSM sequence for 5*3 and for -7*6 (0xF9*0x06), pulsing mult_DONE at the end -> product=0x000F and 0xFFD6; product_valid high for exactly 1 cycle each.
- Boundary operands -128*-128 (0x80*0x80) and -128*1 -> product=0x4000 and 0xFF80 (exercises the N+1-bit A).
- Illegal controls: add_M=subs_M=1 -> A unchanged, ctrl_err pulses 1 cycle. shift_all with load_Q -> Q loaded, no shift, ctrl_err pulses.
- mult_DONE held high 4 cycles -> one product_valid pulse. Pull reset low mid-run -> all outputs 0 asynchronously; next run gives the correct product.
